// File: rtl/timer_delay_scheduler.sv
// Round-robin scheduler that time-shares one interval timer among N_REQ delay
// requesters: programs the timer over its register port, waits for the IRQ, pulses done.
module timer_delay_scheduler #(
  parameter int N_REQ = 7
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [32*N_REQ-1:0]    req_ticks,
  output logic [N_REQ-1:0]       done,
  output logic [N_REQ-1:0]       grant,
  output logic                   busy,
  output logic [2:0]             tmr_address,
  output logic                   tmr_chipselect,
  output logic                   tmr_write_n,
  output logic [15:0]            tmr_writedata,
  input  logic                   tmr_irq,
  output logic [3:0]             debug_state
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [2:0]  ADDR_STATUS   = 3'd0;
  localparam logic [2:0]  ADDR_CONTROL  = 3'd1;
  localparam logic [2:0]  ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0]  ADDR_PERIOD_H = 3'd3;
  localparam logic [15:0] CTRL_STOP     = 16'h0008;
  localparam logic [15:0] CTRL_START    = 16'h0005;

  typedef enum logic [3:0] {
    S_IDLE, S_ARB, S_SHORT, S_WR_STOP, S_WR_PL, S_WR_PH, S_WR_CLR,
    S_WR_START, S_WAIT, S_ACK, S_ABORT, S_ABORT_CLR
  } state_t;

  state_t           state, state_nx;
  logic [PW-1:0]    ptr, ptr_nx;
  logic [31:0]      ticks, ticks_nx, ticks_m1;
  logic [N_REQ-1:0] grant_nx, done_nx;
  logic             busy_nx, cs_nx, write_n_nx;
  logic [2:0]       address_nx;
  logic [15:0]      writedata_nx;

  logic             arb_found;
  logic [PW-1:0]    arb_idx;
  logic [PW:0]      arb_pos;
  logic [N_REQ-1:0] arb_onehot;
  logic [31:0]      arb_ticks;

  // Scan from the pointer upwards, wrapping, and take the first active request.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_pos   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      arb_pos = {1'b0, ptr} + (PW+1)'(k);
      if (arb_pos >= (PW+1)'(N_REQ)) arb_pos = arb_pos - (PW+1)'(N_REQ);
      if (!arb_found && req[arb_pos[PW-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = arb_pos[PW-1:0];
      end
    end
  end

  always_comb begin
    arb_ticks = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_idx == PW'(i)) arb_ticks = req_ticks[32*i +: 32];
    end
  end

  assign arb_onehot = N_REQ'(1) << arb_idx;
  assign ticks_m1   = ticks - 32'd1;

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    ticks_nx = ticks;
    grant_nx = grant;
    done_nx  = '0;
    case (state)
      S_IDLE:      if (|req) state_nx = S_ARB;
      S_ARB: begin
        if (arb_found) begin
          grant_nx = arb_onehot;
          ticks_nx = arb_ticks;
          ptr_nx   = (arb_idx == PW'(N_REQ-1)) ? '0 : arb_idx + PW'(1);
          // A period of 0 never produces a zero edge, so tiny delays bypass the timer.
          if (arb_ticks < 32'd2) begin
            state_nx = S_SHORT;
            done_nx  = arb_onehot;
          end else begin
            state_nx = S_WR_STOP;
          end
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_SHORT:     state_nx = S_IDLE;
      S_WR_STOP:   state_nx = S_WR_PL;
      S_WR_PL:     state_nx = S_WR_PH;
      S_WR_PH:     state_nx = S_WR_CLR;
      S_WR_CLR:    state_nx = S_WR_START;
      S_WR_START:  state_nx = S_WAIT;
      S_WAIT: begin
        // IRQ takes priority over a simultaneous cancel.
        if (tmr_irq) begin
          state_nx = S_ACK;
          done_nx  = grant;
        end else if (!(|(req & grant))) begin
          state_nx = S_ABORT;
        end
      end
      S_ACK:       state_nx = S_IDLE;
      S_ABORT:     state_nx = S_ABORT_CLR;
      S_ABORT_CLR: state_nx = S_IDLE;
      default:     state_nx = S_IDLE;
    endcase
    if (state_nx == S_IDLE) grant_nx = '0;
  end

  // Bus outputs are decoded from the next state so they are registered with it.
  always_comb begin
    busy_nx      = (state_nx != S_IDLE);
    cs_nx        = 1'b0;
    write_n_nx   = 1'b1;
    address_nx   = ADDR_STATUS;
    writedata_nx = '0;
    case (state_nx)
      S_WR_STOP, S_ABORT: begin
        cs_nx        = 1'b1;
        write_n_nx   = 1'b0;
        address_nx   = ADDR_CONTROL;
        writedata_nx = CTRL_STOP;
      end
      S_WR_PL: begin
        cs_nx        = 1'b1;
        write_n_nx   = 1'b0;
        address_nx   = ADDR_PERIOD_L;
        writedata_nx = ticks_m1[15:0];
      end
      S_WR_PH: begin
        cs_nx        = 1'b1;
        write_n_nx   = 1'b0;
        address_nx   = ADDR_PERIOD_H;
        writedata_nx = ticks_m1[31:16];
      end
      S_WR_CLR, S_ACK, S_ABORT_CLR: begin
        cs_nx        = 1'b1;
        write_n_nx   = 1'b0;
        address_nx   = ADDR_STATUS;
        writedata_nx = 16'h0000;
      end
      S_WR_START: begin
        cs_nx        = 1'b1;
        write_n_nx   = 1'b0;
        address_nx   = ADDR_CONTROL;
        writedata_nx = CTRL_START;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      ptr            <= '0;
      ticks          <= '0;
      grant          <= '0;
      done           <= '0;
      busy           <= 1'b0;
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_address    <= '0;
      tmr_writedata  <= '0;
    end else begin
      state          <= state_nx;
      ptr            <= ptr_nx;
      ticks          <= ticks_nx;
      grant          <= grant_nx;
      done           <= done_nx;
      busy           <= busy_nx;
      tmr_chipselect <= cs_nx;
      tmr_write_n    <= write_n_nx;
      tmr_address    <= address_nx;
      tmr_writedata  <= writedata_nx;
    end
  end

  assign debug_state = state;

endmodule

// File: tb/tb_timer_delay_scheduler.sv
// Directed bench for timer_delay_scheduler with a behavioural interval timer,
// expected bus writes and done pulses queued by the driver and popped by a monitor.
module tb_timer_delay_scheduler;

  localparam int N  = 7;
  localparam int WW = 3 + 16 + 32;
  localparam int DW = N + 32;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [N-1:0]     req = '0;
  logic [32*N-1:0]  req_ticks = '0;
  logic [N-1:0]     done, grant;
  logic             busy;
  logic [2:0]       tmr_address;
  logic             tmr_chipselect, tmr_write_n;
  logic [15:0]      tmr_writedata;
  logic             tmr_irq;
  logic [3:0]       debug_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [WW-1:0] exp_q[$];
  logic [DW-1:0] exp_done_q[$];

  // Timer model: counts period..0, raises IRQ one cycle after reaching zero.
  logic [31:0] t_period = '0;
  logic [31:0] t_count = '0;
  logic        t_run = 1'b0;
  logic        t_irq = 1'b0;
  logic        force_irq = 1'b0;
  logic        cap_wr = 1'b0;
  logic [2:0]  cap_addr = '0;
  logic [15:0] cap_data = '0;

  assign tmr_irq = t_irq | force_irq;

  timer_delay_scheduler #(.N_REQ(N)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req            (req),
    .req_ticks      (req_ticks),
    .done           (done),
    .grant          (grant),
    .busy           (busy),
    .tmr_address    (tmr_address),
    .tmr_chipselect (tmr_chipselect),
    .tmr_write_n    (tmr_write_n),
    .tmr_writedata  (tmr_writedata),
    .tmr_irq        (tmr_irq),
    .debug_state    (debug_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    cap_wr   = tmr_chipselect && !tmr_write_n;
    cap_addr = tmr_address;
    cap_data = tmr_writedata;
  end

  always begin
    @(posedge clk);
    #1;
    if (cap_wr && cap_addr == 3'd1 && cap_data[2]) begin
      t_count = t_period;
      t_run   = 1'b1;
    end else if (t_run) begin
      if (t_count == 0) begin
        t_irq = 1'b1;
        t_run = 1'b0;
      end else begin
        t_count = t_count - 1;
      end
    end
    if (cap_wr) begin
      case (cap_addr)
        3'd0: t_irq = 1'b0;
        3'd1: if (cap_data[3]) t_run = 1'b0;
        3'd2: begin t_period[15:0]  = cap_data; t_run = 1'b0; end
        3'd3: begin t_period[31:16] = cap_data; t_run = 1'b0; end
        default: ;
      endcase
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [WW-1:0] e;
    logic [DW-1:0] d;
    if (tmr_chipselect && !tmr_write_n) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL bus_write: unexpected addr=%0d data=%h at cycle %0d, required no write",
                 tmr_address, tmr_writedata, cyc);
      end else begin
        e = exp_q.pop_front();
        if ({tmr_address, tmr_writedata, 32'(cyc)} !== e) begin
          failures++;
          $display("FAIL bus_write: got addr=%0d data=%h cycle=%0d, required addr=%0d data=%h cycle=%0d",
                   tmr_address, tmr_writedata, cyc, e[50:48], e[47:32], e[31:0]);
        end
      end
    end
    if (done != '0) begin
      checks++;
      if (exp_done_q.size() == 0) begin
        failures++;
        $display("FAIL done_pulse: unexpected done=%b at cycle %0d, required none", done, cyc);
      end else begin
        d = exp_done_q.pop_front();
        if ({done, 32'(cyc)} !== d) begin
          failures++;
          $display("FAIL done_pulse: got done=%b cycle=%0d, required done=%b cycle=%0d",
                   done, cyc, d[DW-1:32], d[31:0]);
        end
      end
    end
  end

  // Driver tasks
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_cycle(input int c);
    while (cyc < c) tick();
  endtask

  task automatic set_req(input int idx, input logic [31:0] t);
    req_ticks[32*idx +: 32] = t;
    req[idx] = 1'b1;
  endtask

  task automatic push_wr(input logic [2:0] a, input logic [15:0] d, input int c);
    exp_q.push_back({a, d, 32'(c)});
  endtask

  task automatic push_done(input int idx, input int c);
    logic [N-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    exp_done_q.push_back({v, 32'(c)});
  endtask

  task automatic push_prog(input int t0, input logic [31:0] t);
    logic [31:0] p;
    p = t - 32'd1;
    push_wr(3'd1, 16'h0008, t0 + 2);
    push_wr(3'd2, p[15:0],  t0 + 3);
    push_wr(3'd3, p[31:16], t0 + 4);
    push_wr(3'd0, 16'h0000, t0 + 5);
    push_wr(3'd1, 16'h0005, t0 + 6);
  endtask

  task automatic push_served(input int idx, input int t0, input int t);
    if (t < 2) begin
      push_done(idx, t0 + 2);
    end else begin
      push_prog(t0, 32'(t));
      push_wr(3'd0, 16'h0000, t0 + t + 8);
      push_done(idx, t0 + t + 8);
    end
  endtask

  task automatic wait_done(input int idx, input int limit);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < limit && !hit; i++) begin
      @(negedge clk);
      if (done[idx]) hit = 1'b1;
    end
    if (!hit) begin
      checks++;
      failures++;
      $display("FAIL wait_done_%0d: no pulse within %0d cycles, required one", idx, limit);
    end
    req[idx] = 1'b0;
  endtask

  task automatic reset_assert();
    reset_n   = 1'b0;
    req       = '0;
    force_irq = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_done", 64'(done), 64'(0));
    check("rst_grant", 64'(grant), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_cs", 64'(tmr_chipselect), 64'(0));
    check("rst_write_n", 64'(tmr_write_n), 64'(1));
    check("rst_addr", 64'(tmr_address), 64'(0));
    check("rst_wdata", 64'(tmr_writedata), 64'(0));
    check("rst_state", 64'(debug_state), 64'(0));
  endtask

  task automatic reset_release();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int t0;

    // Single request, with req_ticks disturbed after grant
    reset_assert();
    reset_release();
    tick();
    set_req(3, 32'd100);
    t0 = cyc;
    push_served(3, t0, 100);
    at_cycle(t0 + 3);
    req_ticks[32*3 +: 32] = 32'd5;
    at_cycle(t0 + 7);
    @(negedge clk);
    check("wait_grant", 64'(grant), 64'(7'b0001000));
    check("wait_busy", 64'(busy), 64'(1));
    wait_done(3, 200);
    @(negedge clk);
    check("after_done", 64'(done), 64'(0));
    check("after_grant", 64'(grant), 64'(0));
    check("after_busy", 64'(busy), 64'(0));

    // Round-robin from reset: 0,2,6; then 0 alone; then 1 before 0
    reset_assert();
    set_req(0, 32'd10);
    set_req(2, 32'd10);
    set_req(6, 32'd10);
    reset_release();
    t0 = cyc;
    push_served(0, t0, 10);
    push_served(2, t0 + 19, 10);
    push_served(6, t0 + 38, 10);
    wait_done(0, 50);
    wait_done(2, 50);
    wait_done(6, 50);
    tick();
    set_req(0, 32'd10);
    t0 = cyc;
    push_served(0, t0, 10);
    wait_done(0, 50);
    tick();
    set_req(0, 32'd10);
    set_req(1, 32'd10);
    t0 = cyc;
    push_served(1, t0, 10);
    push_served(0, t0 + 19, 10);
    wait_done(1, 50);
    wait_done(0, 50);

    // Short delays bypass the timer; ticks=2 is the smallest programmed delay
    tick();
    set_req(4, 32'd0);
    push_served(4, cyc, 0);
    wait_done(4, 10);
    tick();
    set_req(5, 32'd1);
    push_served(5, cyc, 1);
    wait_done(5, 10);
    tick();
    set_req(2, 32'd2);
    push_served(2, cyc, 2);
    wait_done(2, 30);

    // Cancel during WAIT
    tick();
    set_req(1, 32'd1000);
    t0 = cyc;
    push_prog(t0, 32'd1000);
    push_wr(3'd1, 16'h0008, t0 + 51);
    push_wr(3'd0, 16'h0000, t0 + 52);
    at_cycle(t0 + 50);
    req[1] = 1'b0;
    at_cycle(t0 + 52);
    @(negedge clk);
    check("abort_clr_busy", 64'(busy), 64'(1));
    @(negedge clk);
    check("abort_idle_busy", 64'(busy), 64'(0));
    check("abort_idle_grant", 64'(grant), 64'(0));

    // IRQ and cancel in the same cycle: IRQ wins
    tick();
    set_req(1, 32'd1000);
    t0 = cyc;
    push_prog(t0, 32'd1000);
    push_wr(3'd0, 16'h0000, t0 + 51);
    push_done(1, t0 + 51);
    at_cycle(t0 + 50);
    force_irq = 1'b1;
    req[1] = 1'b0;
    at_cycle(t0 + 51);
    force_irq = 1'b0;
    wait_done(1, 5);

    // Wide delay spanning both period halves
    tick();
    tick();
    set_req(6, 32'h0001_0005);
    push_served(6, cyc, 32'h0001_0005);
    wait_done(6, 65600);

    // Reset in WAIT leaves the timer running; next grant recovers it
    tick();
    set_req(3, 32'd500);
    t0 = cyc;
    push_prog(t0, 32'd500);
    at_cycle(t0 + 30);
    reset_assert();
    reset_release();
    set_req(0, 32'd20);
    push_served(0, cyc, 20);
    wait_done(0, 40);

    repeat (5) @(negedge clk);
    check("leftover_writes", 64'(exp_q.size()), 64'(0));
    check("leftover_dones", 64'(exp_done_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
